pipelined_age_permuter: RTL and testbench

- Parametrised, pipelined successor to the router's 4-port age-sorting permutation network.
- Routes N flits through a log2(N)-stage tournament butterfly of 2x2 swap cells, with one register stage per butterfly level.
- Guarantees the highest-priority (oldest valid) flit exits on lane 0, ahead of port allocation.
- Adds a per-lane valid qualifier, a pipeline stall, a per-flit sort direction and optional age increment while stalled.

---
 rtl/pipelined_age_permuter.sv | 114 +++++++++++
 tb/tb_pipelined_age_permuter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_age_permuter.sv
// Pipelined tournament butterfly that steers the oldest valid flit to lane 0
// (or lane NUM_PORTS-1 when sort_dir=1), one register stage per butterfly level.
module pipelined_age_permuter #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned TIME_LSB     = 0,
  parameter int unsigned TIME_W       = 8,
  parameter int unsigned AGE_ON_STALL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       sort_dir,
  input  logic [NUM_PORTS*WIDTH-1:0] din,
  input  logic [NUM_PORTS-1:0]       din_valid,
  output logic [NUM_PORTS*WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]       dout_valid,
  output logic                       busy
);

  localparam int unsigned STAGES = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  function automatic logic beats(input logic va, input logic [TIME_W-1:0] aa,
                                 input logic vb, input logic [TIME_W-1:0] ab);
    return va && (!vb || (aa > ab));
  endfunction

  function automatic logic [WIDTH-1:0] aged(input logic [WIDTH-1:0] f);
    logic [WIDTH-1:0]  r;
    logic [TIME_W-1:0] a;
    r = f;
    a = f[TIME_LSB +: TIME_W];
    if (a != {TIME_W{1'b1}}) r[TIME_LSB +: TIME_W] = a + 1'b1;
    return r;
  endfunction

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0]     src_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0] src_valid;
    logic                 src_dir;
    logic [WIDTH-1:0]     sw_flit  [NUM_PORTS];
    logic [NUM_PORTS-1:0] sw_valid;
    logic [WIDTH-1:0]     flit_q   [NUM_PORTS];
    logic [NUM_PORTS-1:0] valid_q;
    logic                 dir_q;
    logic                 busy_chain;

    if (s == 0) begin : g_src
      always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) src_flit[k] = din[k*WIDTH +: WIDTH];
        src_valid = din_valid;
        src_dir   = sort_dir;
      end
      assign busy_chain = |valid_q;
    end else begin : g_src
      always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) src_flit[k] = g_stage[s-1].flit_q[k];
        src_valid = g_stage[s-1].valid_q;
        src_dir   = g_stage[s-1].dir_q;
      end
      assign busy_chain = (|valid_q) | g_stage[s-1].busy_chain;
    end

    // 2x2 swap cells: lane i (bit s clear) against lane i + 2^s; ties never swap.
    always_comb begin
      for (int k = 0; k < NUM_PORTS; k++) sw_flit[k] = src_flit[k];
      sw_valid = src_valid;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (((i >> s) & 1) == 0) begin
          int  j;
          logic swap;
          j = i + (1 << s);
          if (src_dir) begin
            swap = beats(src_valid[i], src_flit[i][TIME_LSB +: TIME_W],
                         src_valid[j], src_flit[j][TIME_LSB +: TIME_W]);
          end else begin
            swap = beats(src_valid[j], src_flit[j][TIME_LSB +: TIME_W],
                         src_valid[i], src_flit[i][TIME_LSB +: TIME_W]);
          end
          if (swap) begin
            sw_flit[i]  = src_flit[j];
            sw_flit[j]  = src_flit[i];
            sw_valid[i] = src_valid[j];
            sw_valid[j] = src_valid[i];
          end
        end
      end
    end

    // The output register is never aged so dout stays stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < NUM_PORTS; k++) flit_q[k] <= '0;
        valid_q <= '0;
        dir_q   <= 1'b0;
      end else if (!stall) begin
        for (int k = 0; k < NUM_PORTS; k++) flit_q[k] <= sw_flit[k];
        valid_q <= sw_valid;
        dir_q   <= src_dir;
      end else if ((AGE_ON_STALL != 0) && (s != STAGES - 1)) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (valid_q[k]) flit_q[k] <= aged(flit_q[k]);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) dout[k*WIDTH +: WIDTH] = g_stage[STAGES-1].flit_q[k];
    dout_valid = g_stage[STAGES-1].valid_q;
    busy       = g_stage[STAGES-1].busy_chain;
  end

endmodule

// File: tb/tb_pipelined_age_permuter.sv
// Directed and streaming checks for pipelined_age_permuter (4 lanes, 16-bit flits, 4-bit age).
module tb_pipelined_age_permuter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        sort_dir = 1'b0;
  logic [63:0] din = '0;
  logic [3:0]  din_valid = '0;
  logic [63:0] dout;
  logic [3:0]  dout_valid;
  logic        busy;

  int checks = 0;
  int failures = 0;

  pipelined_age_permuter #(
    .NUM_PORTS(4), .WIDTH(16), .TIME_LSB(0), .TIME_W(4), .AGE_ON_STALL(1)
  ) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .sort_dir(sort_dir),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Streaming scoreboard state: two-deep shadow of the pipeline.
  logic [63:0] p0_d, p1_d, cur_d;
  logic [3:0]  p0_v, p1_v, cur_v;
  logic        p0_dir, p1_dir, cur_dir;
  bit          p0_live, p1_live;

  initial begin
    // Reset state
    #2;
    chk("reset_dout", dout, 64'h0);
    chk("reset_valid", {60'h0, dout_valid}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    #10 reset = 1'b1;
    step();

    // Basic sort, latency 2
    din = 64'h0041_0037_0025_0013; din_valid = 4'hF; sort_dir = 1'b0;
    step();
    din_valid = 4'h0; din = '0;
    step();
    chk("sort_dout", dout, 64'h0041_0025_0013_0037);
    chk("sort_valid", {60'h0, dout_valid}, 64'hF);
    chk("sort_busy", {63'h0, busy}, 64'h1);
    step();

    // Reset mid-flight
    din = 64'h0041_0037_0025_0013; din_valid = 4'hF;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("midrst_dout", dout, 64'h0);
    chk("midrst_valid", {60'h0, dout_valid}, 64'h0);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    din_valid = 4'h0; din = '0;
    #2 reset = 1'b1;
    step();

    // Valid dominance
    din = 64'h00FF_0000_0002_0000; din_valid = 4'b0010;
    step();
    din_valid = 4'h0; din = '0;
    step();
    chk("vdom_dout", dout, 64'h00FF_0000_0000_0002);
    chk("vdom_valid", {60'h0, dout_valid}, 64'h1);

    // Ties never swap
    din = 64'h0045_0035_0025_0015; din_valid = 4'hF;
    step();
    din_valid = 4'h0; din = '0;
    step();
    chk("tie_dout", dout, 64'h0045_0035_0025_0015);
    chk("tie_valid", {60'h0, dout_valid}, 64'hF);

    // sort_dir=1 then flip on the following set
    din = 64'h0041_0037_0025_0013; din_valid = 4'hF; sort_dir = 1'b1;
    step();
    sort_dir = 1'b0;
    step();
    chk("dir1_dout", dout, 64'h0037_0013_0025_0041);
    chk("dir1_valid", {60'h0, dout_valid}, 64'hF);
    din_valid = 4'h0; din = '0;
    step();
    chk("dirflip_dout", dout, 64'h0041_0025_0013_0037);

    // Stall aging: aging set held in stage 0 while the tie set sits on dout
    din = 64'h0045_0035_0025_0015; din_valid = 4'hF;
    step();
    din = 64'h0000_0000_0003_001E; din_valid = 4'b0001;
    step();
    stall = 1'b1; din = '1; din_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall_dout%0d", c), dout, 64'h0045_0035_0025_0015);
      chk($sformatf("stall_valid%0d", c), {60'h0, dout_valid}, 64'hF);
    end
    chk("stall_busy", {63'h0, busy}, 64'h1);
    stall = 1'b0; din = '0; din_valid = 4'h0;
    step();
    chk("aged_dout", dout, 64'h0000_0000_0003_001F);
    chk("aged_valid", {60'h0, dout_valid}, 64'h1);
    step();
    step();
    chk("drain_busy", {63'h0, busy}, 64'h0);

    // Streaming with random stall: latency, multiset of tags, oldest-lane guarantee
    p0_live = 0; p1_live = 0;
    p0_d = '0; p1_d = '0; p0_v = '0; p1_v = '0; p0_dir = 0; p1_dir = 0;
    for (int n = 0; n < 300; n++) begin
      logic s_now;
      for (int k = 0; k < 4; k++) begin
        logic [11:0] tag;
        logic [3:0]  age;
        tag = {n[7:0], k[3:0]};
        age = 4'($urandom_range(0, 15));
        cur_d[k*16 +: 16] = {tag, age};
      end
      cur_v   = 4'($urandom_range(0, 15));
      cur_dir = 1'($urandom_range(0, 1));
      s_now   = ($urandom_range(0, 3) == 0);
      din = cur_d; din_valid = cur_v; sort_dir = cur_dir; stall = s_now;
      step();
      if (!s_now) begin
        p1_d = p0_d; p1_v = p0_v; p1_dir = p0_dir; p1_live = p0_live;
        p0_d = cur_d; p0_v = cur_v; p0_dir = cur_dir; p0_live = 1;
        if (p1_live) begin
          int nin, nout, w;
          logic [3:0] wage;
          nin = 0; nout = 0;
          for (int k = 0; k < 4; k++) begin
            if (p1_v[k]) nin++;
            if (dout_valid[k]) nout++;
          end
          chk($sformatf("strm_count%0d", n), 64'(nout), 64'(nin));
          for (int k = 0; k < 4; k++) begin
            if (p1_v[k]) begin
              int hits;
              hits = 0;
              for (int m = 0; m < 4; m++) begin
                if (dout_valid[m] && (dout[m*16+4 +: 12] == p1_d[k*16+4 +: 12])) hits++;
              end
              chk($sformatf("strm_tag%0d_%0d", n, k), 64'(hits), 64'd1);
            end
          end
          if (nin > 0) begin
            w = p1_dir ? 3 : 0;
            wage = dout[w*16 +: 4];
            chk($sformatf("strm_winvalid%0d", n), {63'h0, dout_valid[w]}, 64'h1);
            for (int m = 0; m < 4; m++) begin
              if (dout_valid[m]) begin
                chk($sformatf("strm_oldest%0d_%0d", n, m),
                    {63'h0, (wage >= dout[m*16 +: 4])}, 64'h1);
              end
            end
          end
        end
      end
    end
    stall = 1'b0; din_valid = '0;
    step();
    step();
    step();
    chk("final_busy", {63'h0, busy}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
